ac_dac_feeder: RTL
==================

// Module: ac_dac_feeder
// PURPOSE
//   Playback buffer upstream of the audio codec serial interface. Accepts stereo
//   samples from the user stream (valid/ready), buffers them in a FIFO, and presents
//   one stereo pair on genDataL/genDataR per sample period, advancing on the codec tick.
//   Handles underrun and flush, and reports FIFO level and underrun statistics.
// PARAMETERS
//   DATA_WDT      24        sample width, signed; 16, 20, 24 or 32
//   FIFO_DEPTH    16        stereo pairs stored; power of 2, >= 2
//   UNDERRUN_MODE "ZERO"    "ZERO": output 0 on underrun; "HOLD": repeat last pair
// PORTS
//   clk        in   1                      system clock (codec mclk domain)
//   reset      in   1                      synchronous, active-high
//   cmdModEn   in   1                      codec module enable; low = flush and idle
//   inValid    in   1                      upstream sample pair valid
//   inReady    out  1                      feeder can accept a pair this cycle
//   inDataL    in   DATA_WDT               left sample, signed
//   inDataR    in   DATA_WDT               right sample, signed
//   tick       in   1                      1-cycle pulse per frame from codec interface
//   genDataL   out  DATA_WDT               left sample to codec interface, signed
//   genDataR   out  DATA_WDT               right sample to codec interface, signed
//   fifoLevel  out  $clog2(FIFO_DEPTH)+1   pairs currently stored, 0..FIFO_DEPTH
//   underrun   out  1                      1-cycle pulse: tick arrived with FIFO empty
//   underCnt   out  16                     underrun count, saturating at 16'hFFFF
//   clrCnt     in   1                      synchronous clear of underCnt
// BEHAVIOUR
// - Reset: FIFO empty; outputs genDataL/R=0, fifoLevel=0, inReady=0, underrun=0,
//   underCnt=0. inReady rises the first cycle after reset deasserts, if cmdModEn=1.
// - Storage: circular buffer. Write and read pointers are log2(FIFO_DEPTH) bits and
//   wrap naturally. Full and empty come from a separate level counter.
// - inReady = cmdModEn & ~full. It is registered-state based and does not include the
//   same-cycle pop. Push occurs when inValid & inReady.
// - Pop: on a cycle with tick=1 and cmdModEn=1:
//   - If not empty: genDataL/R <= head pair on the next clk edge, so outputs update
//     on the cycle after tick; read pointer advances; level decrements.
//   - If empty: underrun=1 on the next cycle; underCnt increments unless saturated;
//     genDataL/R <= 0 in "ZERO" mode, or unchanged in "HOLD" mode.
// - Empty is evaluated on pre-edge state. A push in the same cycle as a tick on an
//   empty FIFO is stored but not popped, and counts as an underrun.
// - Push and pop in the same cycle on a non-empty FIFO leaves the level unchanged.
// - genDataL/R stay stable from the cycle after tick until the next tick. They are
//   always valid for the interface's latch at the start of the next frame.
// - cmdModEn=0:
//   - FIFO flushed: pointers and level set to 0.
//   - genDataL/R=0, inReady=0, underrun=0.
//   - Ticks are ignored.
//   - underCnt holds its value.
// - clrCnt=1 sets underCnt=0 on the next edge and takes priority over a coincident
//   increment.
// - Widths: data is passed bit-exact with no arithmetic. fifoLevel never exceeds
//   FIFO_DEPTH.
// - Elaboration: $error on illegal DATA_WDT, FIFO_DEPTH or UNDERRUN_MODE values.
// TESTING
// 1. Push pairs (L,R) = (24'h000001,24'hFFFFFF), (24'h7FFFFF,24'h800000), then 2 ticks
//    -> genData shows each pair the cycle after its tick; fifoLevel 2->1->0.
// 2. Push 16 pairs with inValid held high
//    -> inReady=0 after the 16th, fifoLevel=16. One tick -> inReady=1 again, level=15.
// 3. Tick with FIFO empty in "ZERO" mode, with prior output 24'h123456
//    -> underrun pulse, underCnt=1, genData=0. In "HOLD" mode genData stays 24'h123456.
// 4. Same-cycle push and tick on an empty FIFO
//    -> underrun=1, fifoLevel=1. The pushed pair is output on the following tick.
// 5. Drop cmdModEn with fifoLevel=5
//    -> next cycle fifoLevel=0, genData=0, inReady=0. Ticks are ignored while it is low.
// 6. Force underCnt to 16'hFFFF, then another underrun -> stays 16'hFFFF.
//    clrCnt together with an underrun -> 0. Reset mid-push -> all outputs 0.

Source files
------------

// File: rtl/ac_dac_feeder.sv
// ac_dac_feeder: stereo playback FIFO that feeds the codec serial interface.
// It accepts sample pairs over valid/ready and presents one pair per codec tick.
// It handles underrun (zero or hold output) and flush.
// It reports the FIFO level and a saturating underrun count.
module ac_dac_feeder #(
    parameter int unsigned DATA_WDT      = 24,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter string       UNDERRUN_MODE = "ZERO"
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cmdModEn,
    input  logic                              inValid,
    output logic                              inReady,
    input  logic [DATA_WDT-1:0]               inDataL,
    input  logic [DATA_WDT-1:0]               inDataR,
    input  logic                              tick,
    output logic [DATA_WDT-1:0]               genDataL,
    output logic [DATA_WDT-1:0]               genDataR,
    output logic [$clog2(FIFO_DEPTH):0]       fifoLevel,
    output logic                              underrun,
    output logic [15:0]                       underCnt,
    input  logic                              clrCnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam bit HOLD_MODE = (UNDERRUN_MODE == "HOLD");

    if (!(DATA_WDT == 16 || DATA_WDT == 20 || DATA_WDT == 24 || DATA_WDT == 32)) begin : g_bad_wdt
        $error("ac_dac_feeder: DATA_WDT must be 16, 20, 24 or 32");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ac_dac_feeder: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (!(UNDERRUN_MODE == "ZERO" || UNDERRUN_MODE == "HOLD")) begin : g_bad_mode
        $error("ac_dac_feeder: UNDERRUN_MODE must be \"ZERO\" or \"HOLD\"");
    end

    logic [DATA_WDT-1:0] r_memL [FIFO_DEPTH];
    logic [DATA_WDT-1:0] r_memR [FIFO_DEPTH];
    logic [AW-1:0]       r_wrPtr;
    logic [AW-1:0]       r_rdPtr;
    logic [LW-1:0]       r_level;
    logic [DATA_WDT-1:0] r_genL;
    logic [DATA_WDT-1:0] r_genR;
    logic                r_underrun;
    logic [15:0]         r_underCnt;

    logic w_full;
    logic w_empty;
    logic w_ready;
    logic w_push;
    logic w_pop;
    logic w_under;

    // Handshake and pop decisions are made from the pre-edge registered state only.
    always_comb begin
        w_full  = (r_level == LW'(FIFO_DEPTH));
        w_empty = (r_level == '0);
        w_ready = cmdModEn & ~w_full & ~reset;
        w_push  = inValid & w_ready;
        w_pop   = tick & cmdModEn & ~w_empty;
        w_under = tick & cmdModEn & w_empty;
    end

    // Sample storage. It is written on push and needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memL[r_wrPtr] <= inDataL;
            r_memR[r_wrPtr] <= inDataR;
        end
    end

    // Pointers and level. A disabled module flushes the FIFO.
    always_ff @(posedge clk) begin
        if (reset || !cmdModEn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Output pair register: it is loaded on tick and handles the underrun policy.
    always_ff @(posedge clk) begin
        if (reset || !cmdModEn) begin
            r_genL <= '0;
            r_genR <= '0;
        end else if (w_pop) begin
            r_genL <= r_memL[r_rdPtr];
            r_genR <= r_memR[r_rdPtr];
        end else if (w_under && !HOLD_MODE) begin
            r_genL <= '0;
            r_genR <= '0;
        end
    end

    // Underrun pulse and saturating counter. A clear wins over an increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_underrun <= 1'b0;
            r_underCnt <= '0;
        end else begin
            r_underrun <= w_under;
            if (clrCnt)
                r_underCnt <= '0;
            else if (w_under && r_underCnt != '1)
                r_underCnt <= r_underCnt + 16'd1;
        end
    end

    assign inReady   = w_ready;
    assign genDataL  = r_genL;
    assign genDataR  = r_genR;
    assign fifoLevel = r_level;
    assign underrun  = r_underrun;
    assign underCnt  = r_underCnt;

endmodule
